lift_scheduler: RTL and testbench

//   Multi-floor car controller that sequences the lift. Latches floor calls,

---
 rtl/lift_pkg.sv | 18 +
 rtl/lift_timer.sv | 31 +++
 rtl/lift_scheduler.sv | 203 ++++++++++++++++++++
 tb/tb_lift_scheduler.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lift_pkg.sv
// Shared definitions for the lift controller: FSM state codes, travel
// direction codes and the floor-index width helper.
package lift_pkg;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_MOVE_UP   = 2'd1;
  localparam logic [1:0] ST_MOVE_DOWN = 2'd2;
  localparam logic [1:0] ST_DOOR_OPEN = 2'd3;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Width of a floor index; never below one bit.
  function automatic int fw_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lift_timer.sv
// Loadable down-counter. It counts toward zero and then holds there. The
// expiry flag is high while the count is zero, so a value of N-1 that is
// loaded on an edge gives N cycles before the flag is seen.
module lift_timer #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_expired
);

  logic [W-1:0] r_cnt;

  // Load or count down, then saturate at zero.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/lift_scheduler.sv
// SCAN lift car controller. It latches floor calls and keeps moving in the
// current direction while calls exist beyond the car, stopping at every
// latched floor. It reverses only when nothing remains ahead. The indicators
// follow the lift meaning: green = door open, red = car moving.
module lift_scheduler
  import lift_pkg::*;
#(
  parameter int NUM_FLOORS    = 4,
  parameter int TRAVEL_CYCLES = 3,
  parameter int DOOR_CYCLES   = 4
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic [NUM_FLOORS-1:0]         i_call,
  input  logic                          i_door_hold,
  output logic [fw_of(NUM_FLOORS)-1:0]  o_floor,
  output logic                          o_up,
  output logic                          o_down,
  output logic                          o_door,
  output logic                          o_grn,
  output logic                          o_red,
  output logic [NUM_FLOORS-1:0]         o_pending
);

  localparam int FW = fw_of(NUM_FLOORS);
  localparam int TW = $clog2(TRAVEL_CYCLES + 1);
  localparam int DW = $clog2(DOOR_CYCLES + 1);
  localparam logic [FW-1:0] TOP_FLOOR   = FW'(NUM_FLOORS - 1);
  localparam logic [TW-1:0] TRAVEL_LOAD = TW'(TRAVEL_CYCLES - 1);
  localparam logic [DW-1:0] DOOR_LOAD   = DW'(DOOR_CYCLES - 1);

  logic [1:0]            r_state;
  logic [FW-1:0]         r_floor;
  logic                  r_dir;
  logic [NUM_FLOORS-1:0] r_pending;

  logic [1:0]            w_state_nxt;
  logic [FW-1:0]         w_floor_nxt;
  logic                  w_dir_nxt;
  logic [NUM_FLOORS-1:0] w_served;
  logic                  w_trv_load;
  logic                  w_door_load;
  logic                  w_trv_expired;
  logic                  w_door_expired;
  logic [NUM_FLOORS-1:0] w_above_mask;
  logic [NUM_FLOORS-1:0] w_below_mask;
  logic [NUM_FLOORS-1:0] w_cur_onehot;
  logic [NUM_FLOORS-1:0] w_up_onehot;
  logic [NUM_FLOORS-1:0] w_dn_onehot;
  logic                  w_pend_above;
  logic                  w_pend_below;
  logic                  w_ahead;
  logic                  w_behind;
  logic                  w_hold_req;
  logic [FW-1:0]         w_floor_up;
  logic [FW-1:0]         w_floor_dn;

  lift_timer #(.W(TW)) u_travel_timer (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (w_trv_load),
    .i_load_val (TRAVEL_LOAD),
    .o_expired  (w_trv_expired)
  );

  lift_timer #(.W(DW)) u_door_timer (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (w_door_load),
    .i_load_val (DOOR_LOAD),
    .o_expired  (w_door_expired)
  );

  // Thermometer masks above/below the car and one-hots for this floor and its neighbours.
  always_comb begin
    w_above_mask = '0;
    w_below_mask = '0;
    w_cur_onehot = '0;
    w_up_onehot  = '0;
    w_dn_onehot  = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      w_above_mask[i] = (i > int'(r_floor));
      w_below_mask[i] = (i < int'(r_floor));
      w_cur_onehot[i] = (i == int'(r_floor));
      w_up_onehot[i]  = (i == int'(r_floor) + 1);
      w_dn_onehot[i]  = (i == int'(r_floor) - 1);
    end
  end

  assign w_pend_above = |(r_pending & w_above_mask);
  assign w_pend_below = |(r_pending & w_below_mask);
  assign w_ahead      = (r_dir == DIR_UP) ? w_pend_above : w_pend_below;
  assign w_behind     = (r_dir == DIR_UP) ? w_pend_below : w_pend_above;
  assign w_hold_req   = i_door_hold | (|(i_call & w_cur_onehot));
  assign w_floor_up   = r_floor + FW'(1);
  assign w_floor_dn   = r_floor - FW'(1);

  // SCAN scheduler: choose next state, floor and direction, and which call is served.
  always_comb begin
    w_state_nxt = r_state;
    w_floor_nxt = r_floor;
    w_dir_nxt   = r_dir;
    w_trv_load  = 1'b0;
    w_door_load = 1'b0;
    w_served    = '0;
    case (r_state)
      ST_IDLE: begin
        if (|(r_pending & w_cur_onehot)) begin
          w_state_nxt = ST_DOOR_OPEN;
          w_door_load = 1'b1;
          w_served    = w_cur_onehot;
        end else if (w_ahead) begin
          w_state_nxt = (r_dir == DIR_UP) ? ST_MOVE_UP : ST_MOVE_DOWN;
          w_trv_load  = 1'b1;
        end else if (w_behind) begin
          w_dir_nxt   = (r_dir == DIR_UP) ? DIR_DOWN : DIR_UP;
          w_state_nxt = (r_dir == DIR_UP) ? ST_MOVE_DOWN : ST_MOVE_UP;
          w_trv_load  = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_MOVE_UP: begin
        if (!w_trv_expired) begin
          w_state_nxt = ST_MOVE_UP;
        end else if (r_floor == TOP_FLOOR) begin
          // Cannot go higher; settle rather than leave the shaft.
          w_state_nxt = ST_IDLE;
        end else begin
          w_floor_nxt = w_floor_up;
          if (|(r_pending & w_up_onehot)) begin
            w_state_nxt = ST_DOOR_OPEN;
            w_door_load = 1'b1;
            w_served    = w_up_onehot;
          end else begin
            w_trv_load  = 1'b1;
          end
        end
      end
      ST_MOVE_DOWN: begin
        if (!w_trv_expired) begin
          w_state_nxt = ST_MOVE_DOWN;
        end else if (r_floor == '0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_floor_nxt = w_floor_dn;
          if (|(r_pending & w_dn_onehot)) begin
            w_state_nxt = ST_DOOR_OPEN;
            w_door_load = 1'b1;
            w_served    = w_dn_onehot;
          end else begin
            w_trv_load  = 1'b1;
          end
        end
      end
      ST_DOOR_OPEN: begin
        // A call for the open floor is absorbed by the open door, never latched.
        w_served = w_cur_onehot;
        if (w_hold_req) begin
          w_door_load = 1'b1;
        end else if (!w_door_expired) begin
          w_state_nxt = ST_DOOR_OPEN;
        end else if (w_ahead) begin
          w_state_nxt = (r_dir == DIR_UP) ? ST_MOVE_UP : ST_MOVE_DOWN;
          w_trv_load  = 1'b1;
        end else if (w_behind) begin
          w_dir_nxt   = (r_dir == DIR_UP) ? DIR_DOWN : DIR_UP;
          w_state_nxt = (r_dir == DIR_UP) ? ST_MOVE_DOWN : ST_MOVE_UP;
          w_trv_load  = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Car state, position, direction and call latch.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= ST_IDLE;
      r_floor   <= '0;
      r_dir     <= DIR_UP;
      r_pending <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_floor   <= w_floor_nxt;
      r_dir     <= w_dir_nxt;
      r_pending <= (r_pending | i_call) & ~w_served;
    end
  end

  assign o_floor   = r_floor;
  assign o_up      = (r_state == ST_MOVE_UP);
  assign o_down    = (r_state == ST_MOVE_DOWN);
  assign o_door    = (r_state == ST_DOOR_OPEN);
  assign o_grn     = o_door;
  assign o_red     = o_up | o_down;
  assign o_pending = r_pending;

endmodule

// File: tb/tb_lift_scheduler.sv
// Bench for lift_scheduler: a floor/direction/countdown model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_lift_scheduler;

  localparam int NF     = 4;
  localparam int TRAVEL = 3;
  localparam int DOORC  = 4;
  localparam int M_IDLE = 0;
  localparam int M_MOVE = 1;
  localparam int M_DOOR = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NF-1:0] call = '0;
  logic          door_hold = 1'b0;
  logic [1:0]    floor;
  logic          up, down, door, grn, red;
  logic [NF-1:0] pending;

  int n_total = 0;
  int n_bad   = 0;

  lift_scheduler #(.NUM_FLOORS(NF), .TRAVEL_CYCLES(TRAVEL), .DOOR_CYCLES(DOORC)) dut (
    .i_clk(clk), .i_reset(reset), .i_call(call), .i_door_hold(door_hold),
    .o_floor(floor), .o_up(up), .o_down(down), .o_door(door),
    .o_grn(grn), .o_red(red), .o_pending(pending)
  );

  always #5 clk = ~clk;

  // Model state: what the car is doing, where, which way, and cycles left.
  int          m_floor = 0;
  int          m_dir   = 1;
  int          m_mode  = M_IDLE;
  int          m_left  = 0;
  int          m_served;
  logic [NF-1:0] m_pend = '0;
  bit          m_valid = 1'b0;

  function automatic bit any_beyond(input int f, input int d, input logic [NF-1:0] p);
    for (int i = 0; i < NF; i++)
      if ((i - f) * d > 0 && p[i]) return 1'b1;
    return 1'b0;
  endfunction

  // Model step on each rising edge, using the same inputs the DUT sees.
  always @(posedge clk) begin
    if (reset) begin
      m_floor = 0; m_dir = 1; m_mode = M_IDLE; m_left = 0; m_pend = '0; m_valid = 1'b1;
    end else if (m_valid) begin
      m_served = -1;
      case (m_mode)
        M_IDLE: begin
          if (m_pend[m_floor]) begin
            m_mode = M_DOOR; m_left = DOORC; m_served = m_floor;
          end else if (any_beyond(m_floor, m_dir, m_pend)) begin
            m_mode = M_MOVE; m_left = TRAVEL;
          end else if (any_beyond(m_floor, -m_dir, m_pend)) begin
            m_dir = -m_dir; m_mode = M_MOVE; m_left = TRAVEL;
          end
        end
        M_MOVE: begin
          m_left--;
          if (m_left == 0) begin
            m_floor += m_dir;
            if (m_pend[m_floor]) begin
              m_mode = M_DOOR; m_left = DOORC; m_served = m_floor;
            end else begin
              m_left = TRAVEL;
            end
          end
        end
        default: begin
          m_served = m_floor;
          if (call[m_floor] || door_hold) begin
            m_left = DOORC;
          end else begin
            m_left--;
            if (m_left == 0) begin
              if (any_beyond(m_floor, m_dir, m_pend)) begin
                m_mode = M_MOVE; m_left = TRAVEL;
              end else if (any_beyond(m_floor, -m_dir, m_pend)) begin
                m_dir = -m_dir; m_mode = M_MOVE; m_left = TRAVEL;
              end else begin
                m_mode = M_IDLE;
              end
            end
          end
        end
      endcase
      m_pend = m_pend | call;
      if (m_served >= 0) m_pend[m_served] = 1'b0;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      logic e_up, e_dn, e_door;
      e_up   = (m_mode == M_MOVE) && (m_dir == 1);
      e_dn   = (m_mode == M_MOVE) && (m_dir == -1);
      e_door = (m_mode == M_DOOR);
      n_total++;
      if (int'(floor) != m_floor || up !== e_up || down !== e_dn || door !== e_door ||
          grn !== e_door || red !== (e_up | e_dn) || pending !== m_pend) begin
        n_bad++;
        $display("FAIL cycle_cmp t=%0t got fl=%0d u=%b d=%b door=%b g=%b r=%b p=%b expected fl=%0d u=%b d=%b door=%b p=%b",
                 $time, floor, up, down, door, grn, red, pending,
                 m_floor, e_up, e_dn, e_door, m_pend);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse_call(input logic [NF-1:0] c);
    call = c;
    @(negedge clk);
    call = '0;
  endtask

  // Advance until the door opens, counting motor cycles on the way.
  task automatic run_until_door(input string name, output int ups, output int downs, output int ups_f1);
    ups = 0; downs = 0; ups_f1 = 0;
    for (int k = 0; k < 100 && !door; k++) begin
      if (up) ups++;
      if (down) downs++;
      if (up && floor == 2'd1) ups_f1++;
      @(negedge clk);
    end
    check({name, "_door_reached"}, int'(door), 1);
  endtask

  // Count cycles the door stays open, starting with the current one.
  task automatic count_door(output int n);
    n = 0;
    for (int k = 0; k < 100 && door; k++) begin
      n++;
      @(negedge clk);
    end
  endtask

  int ups, downs, ups_f1, nd, hold_cnt;

  initial begin
    // 1: reset for two cycles, then quiet.
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    check("t1_floor", int'(floor), 0);
    check("t1_outputs", int'({up, down, door, grn, red}), 0);
    check("t1_pending", int'(pending), 0);

    // 2: call at the car's own floor.
    pulse_call(4'b0001);
    run_until_door("t2", ups, downs, ups_f1);
    check("t2_no_motion", ups + downs, 0);
    check("t2_grn", int'(grn), 1);
    count_door(nd);
    check("t2_door_cycles", nd, 4);
    check("t2_pending_after", int'(pending), 0);

    // 3: ground to top floor.
    pulse_call(4'b1000);
    run_until_door("t3", ups, downs, ups_f1);
    check("t3_up_cycles", ups, 9);
    check("t3_up_at_f1", ups_f1, 3);
    check("t3_floor", int'(floor), 3);
    check("t3_pending", int'(pending), 0);
    count_door(nd);
    check("t3_door_cycles", nd, 4);

    // 4: from the top, calls at 2 and 0 together.
    pulse_call(4'b0101);
    run_until_door("t4a", ups, downs, ups_f1);
    check("t4_floor_first", int'(floor), 2);
    check("t4_down_cycles_first", downs, 3);
    count_door(nd);
    check("t4_door_cycles", nd, 4);
    run_until_door("t4b", ups, downs, ups_f1);
    check("t4_no_reversal", ups, 0);
    check("t4_down_cycles_second", downs, 6);
    check("t4_floor_second", int'(floor), 0);
    count_door(nd);

    // 5: call for a passed floor during an upward run.
    pulse_call(4'b1000);
    for (int k = 0; k < 50 && !(floor == 2'd1 && up); k++) @(negedge clk);
    check("t5_at_f1_moving_up", int'(floor == 2'd1 && up), 1);
    pulse_call(4'b0001);
    run_until_door("t5a", ups, downs, ups_f1);
    check("t5_top_first", int'(floor), 3);
    check("t5_pending_kept", int'(pending), 1);
    count_door(nd);
    run_until_door("t5b", ups, downs, ups_f1);
    check("t5_return_floor", int'(floor), 0);
    check("t5_return_downs", downs, 9);
    check("t5_pending_cleared", int'(pending), 0);
    count_door(nd);

    // 6a: door hold at floor 1.
    pulse_call(4'b0010);
    run_until_door("t6", ups, downs, ups_f1);
    check("t6_floor", int'(floor), 1);
    door_hold = 1'b1;
    hold_cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (door) hold_cnt++;
    end
    door_hold = 1'b0;
    check("t6_held_open", hold_cnt, 10);
    count_door(nd);
    check("t6_close_after_release", nd, 4);

    // 6b: reset in the middle of a move.
    pulse_call(4'b1000);
    for (int k = 0; k < 20 && !up; k++) @(negedge clk);
    check("t6_moving", int'(up), 1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t6_reset_outputs", int'({up, down, door, grn, red}), 0);
    check("t6_reset_floor", int'(floor), 0);
    check("t6_reset_pending", int'(pending), 0);
    repeat (4) @(negedge clk);
    check("t6_quiet_after_reset", int'({up, down, door}), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
